// File: rtl/axi_cmd_pkg.sv
// Shared AXI encodings, FSM state type and helpers for the AXI command master.
package axi_cmd_pkg;

  // AXI burst type encodings
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // AXI response encodings
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Command master FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RSP
  } state_e;

  // Ceiling log2, used to derive AxSIZE from the strobe width
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_cmd_master_if.sv
// Bundle of the command stream, response stream and AXI4 master channels.
// master modport: the command master itself (accepts cmd, drives AXI, returns rsp).
// slave modport : the peers (command source / response sink / AXI slave).
interface axi_cmd_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

  // command stream
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [STRB_WIDTH-1:0] cmd_strb;
  logic [ID_WIDTH-1:0]   cmd_id;

  // response stream
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_resp;
  logic                  rsp_err;

  // AXI write address / data / response
  logic [ID_WIDTH-1:0]   m_axi_awid;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [ID_WIDTH-1:0]   m_axi_bid;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  // AXI read address / data
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_strb, cmd_id,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_data, rsp_resp, rsp_err,
    input  rsp_ready,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_strb, cmd_id,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_data, rsp_resp, rsp_err,
    output rsp_ready,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/axi_cmd_master.sv
// Converts a valid/ready single read/write command into one single-beat AXI4
// transaction and returns the result on a valid/ready response stream.
// Ports: clk, rst (async active-low), bus (axi_cmd_master_if.master: cmd, rsp, m_axi_*).
// One transaction in flight; all outputs registered.
module axi_cmd_master
  import axi_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  axi_cmd_master_if.master  bus
);

  localparam logic [2:0] AXSIZE = 3'(clog2(STRB_WIDTH));

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_err_q, rsp_err_d;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  assign cmd_hs = bus.cmd_valid & cmd_ready_q;
  assign aw_hs  = awvalid_q & bus.m_axi_awready;
  assign w_hs   = wvalid_q & bus.m_axi_wready;
  assign b_hs   = bready_q & bus.m_axi_bvalid;
  assign ar_hs  = arvalid_q & bus.m_axi_arready;
  assign r_hs   = rready_q & bus.m_axi_rvalid;
  assign rsp_hs = rsp_valid_q & bus.rsp_ready;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    strb_d      = strb_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          cmd_ready_d = 1'b0;
          write_d     = bus.cmd_write;
          addr_d      = bus.cmd_addr;
          data_d      = bus.cmd_data;
          strb_d      = bus.cmd_strb;
          id_d        = bus.cmd_id;
          if (bus.cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      // AW and W complete independently, in any order
      ST_WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_data_d  = '0;
          rsp_resp_d  = bus.m_axi_bresp;
          rsp_err_d   = (bus.m_axi_bid != id_q);
          state_d     = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_data_d  = bus.m_axi_rdata;
          rsp_resp_d  = bus.m_axi_rresp;
          rsp_err_d   = (bus.m_axi_rid != id_q) | ~bus.m_axi_rlast;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_write     = rsp_write_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_resp      = rsp_resp_q;
  assign bus.rsp_err       = rsp_err_q;

  assign bus.m_axi_awid    = id_q;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = 8'd0;
  assign bus.m_axi_awsize  = AXSIZE;
  assign bus.m_axi_awburst = AXI_BURST_INCR;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_wdata   = data_q;
  assign bus.m_axi_wstrb   = strb_q;
  assign bus.m_axi_wlast   = 1'b1;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready_q;

  assign bus.m_axi_arid    = id_q;
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = 8'd0;
  assign bus.m_axi_arsize  = AXSIZE;
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_cmd_master.sv
// Self-checking bench for axi_cmd_master: behavioural zero-wait AXI RAM slave
// with stall/error knobs, command driver, and a response scoreboard.
module tb_axi_cmd_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_cmd_master_if bus ();

  axi_cmd_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        write;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        err;
    int          lat;   // expected accept-to-rsp_valid cycles, 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   accept_cyc = 0;
  int   bp_cnt   = 0;

  // Slave knobs
  int         aw_stall_until  = 0;
  int         w_stall_until   = 0;
  int         rsp_stall_until = 0;
  logic [7:0] bid_xor     = 8'h00;
  logic [1:0] rresp_force = 2'b00;
  logic       rlast_zero  = 1'b0;

  // Activity counters (monotonic, never reset)
  int          awv_cycles = 0, wv_cycles = 0, rspv_cycles = 0;
  int          aw_hs_cnt = 0, wdata_changes = 0;
  logic        wvalid_prev = 1'b0;
  logic [31:0] wdata_prev = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.m_axi_awvalid) awv_cycles <= awv_cycles + 1;
    if (bus.m_axi_wvalid)  wv_cycles  <= wv_cycles + 1;
    if (bus.rsp_valid)     rspv_cycles <= rspv_cycles + 1;
    if (bus.m_axi_awvalid && bus.m_axi_awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (bus.m_axi_wvalid && wvalid_prev && bus.m_axi_wdata != wdata_prev)
      wdata_changes <= wdata_changes + 1;
    wvalid_prev <= bus.m_axi_wvalid;
    wdata_prev  <= bus.m_axi_wdata;
  end

  // ---------------- behavioural AXI RAM slave ----------------
  logic [31:0] mem [256];
  logic        aw_got, w_got;
  logic [15:0] aw_addr_s;
  logic [7:0]  aw_id_s;
  logic [31:0] w_data_s;
  logic [3:0]  w_strb_s;

  assign bus.m_axi_awready = (awv_cycles >= aw_stall_until);
  assign bus.m_axi_wready  = (wv_cycles >= w_stall_until);
  assign bus.m_axi_arready = 1'b1;
  assign bus.rsp_ready     = (rspv_cycles >= rsp_stall_until);

  wire        aw_hs  = bus.m_axi_awvalid & bus.m_axi_awready;
  wire        w_hs   = bus.m_axi_wvalid & bus.m_axi_wready;
  wire        ar_hs  = bus.m_axi_arvalid & bus.m_axi_arready;
  wire [7:0]  wr_idx = aw_hs ? bus.m_axi_awaddr[9:2] : aw_addr_s[9:2];
  wire [7:0]  wr_id  = aw_hs ? bus.m_axi_awid : aw_id_s;
  wire [31:0] wr_dat = w_hs ? bus.m_axi_wdata : w_data_s;
  wire [3:0]  wr_stb = w_hs ? bus.m_axi_wstrb : w_strb_s;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      aw_addr_s <= 16'd0;
      aw_id_s   <= 8'd0;
      w_data_s  <= 32'd0;
      w_strb_s  <= 4'd0;
      bus.m_axi_bvalid <= 1'b0;
      bus.m_axi_bid    <= 8'd0;
      bus.m_axi_bresp  <= 2'b00;
      bus.m_axi_rvalid <= 1'b0;
      bus.m_axi_rid    <= 8'd0;
      bus.m_axi_rdata  <= 32'd0;
      bus.m_axi_rresp  <= 2'b00;
      bus.m_axi_rlast  <= 1'b0;
    end else begin
      if (bus.m_axi_bvalid && bus.m_axi_bready) bus.m_axi_bvalid <= 1'b0;
      if (bus.m_axi_rvalid && bus.m_axi_rready) bus.m_axi_rvalid <= 1'b0;
      if (aw_hs) begin
        aw_got    <= 1'b1;
        aw_addr_s <= bus.m_axi_awaddr;
        aw_id_s   <= bus.m_axi_awid;
      end
      if (w_hs) begin
        w_got    <= 1'b1;
        w_data_s <= bus.m_axi_wdata;
        w_strb_s <= bus.m_axi_wstrb;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        mem[wr_idx]      <= merge(mem[wr_idx], wr_dat, wr_stb);
        aw_got           <= 1'b0;
        w_got            <= 1'b0;
        bus.m_axi_bvalid <= 1'b1;
        bus.m_axi_bid    <= wr_id ^ bid_xor;
        bus.m_axi_bresp  <= 2'b00;
      end
      if (ar_hs) begin
        bus.m_axi_rvalid <= 1'b1;
        bus.m_axi_rdata  <= mem[bus.m_axi_araddr[9:2]];
        bus.m_axi_rid    <= bus.m_axi_arid ^ bid_xor;
        bus.m_axi_rresp  <= rresp_force;
        bus.m_axi_rlast  <= ~rlast_zero;
      end
    end
  end

  // ---------------- driver / scoreboard ----------------
  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [7:0] id,
                          input logic push, input exp_t e);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    bus.cmd_strb  = s;
    bus.cmd_id    = id;
    while (!bus.cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", 64'(bus.cmd_ready), 64'd1);
    end else begin
      accept_cyc = cyc;
      if (push) exp_q.push_back(e);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Response monitor: compares at negedge, handshake happens at the following posedge
  task automatic monitor();
    exp_t e;
    logic seen, idle_chk;
    seen = 1'b0;
    idle_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (idle_chk) begin
          check("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
          check("idle_bready", 64'(bus.m_axi_bready), 64'd0);
          check("idle_rready", 64'(bus.m_axi_rready), 64'd0);
          idle_chk = 1'b0;
        end
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
          end else begin
            e = exp_q[0];
            if (!seen) begin
              seen = 1'b1;
              if (e.lat != 0) check("latency", 64'(cyc - accept_cyc), 64'(e.lat));
            end
            if (bus.rsp_ready) begin
              check("rsp_write", 64'(bus.rsp_write), 64'(e.write));
              check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
              check("rsp_resp", 64'(bus.rsp_resp), 64'(e.resp));
              check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
              void'(exp_q.pop_front());
              seen = 1'b0;
              idle_chk = 1'b1;
            end else begin
              bp_cnt++;
              check("bp_rsp_data", 64'(bus.rsp_data), 64'(e.data));
              check("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
            end
          end
        end
      end
    end
  endtask

  function automatic exp_t mk(input logic w, input logic [31:0] d, input logic [1:0] r,
                              input logic er, input int lat);
    exp_t e;
    e.write = w;
    e.data  = d;
    e.resp  = r;
    e.err   = er;
    e.lat   = lat;
    return e;
  endfunction

  initial begin
    int s_aw, s_awv, s_wv, s_wdc, s_bp;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 16'd0;
    bus.cmd_data  = 32'd0;
    bus.cmd_strb  = 4'd0;
    bus.cmd_id    = 8'd0;

    // Reset state and constant outputs
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
    check("rst_wvalid", 64'(bus.m_axi_wvalid), 64'd0);
    check("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
    check("rst_bready", 64'(bus.m_axi_bready), 64'd0);
    check("rst_rready", 64'(bus.m_axi_rready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("awlen", 64'(bus.m_axi_awlen), 64'd0);
    check("arlen", 64'(bus.m_axi_arlen), 64'd0);
    check("awsize", 64'(bus.m_axi_awsize), 64'd2);
    check("arsize", 64'(bus.m_axi_arsize), 64'd2);
    check("awburst", 64'(bus.m_axi_awburst), 64'd1);
    check("arburst", 64'(bus.m_axi_arburst), 64'd1);
    check("wlast", 64'(bus.m_axi_wlast), 64'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    fork monitor(); join_none

    // Write then read back, zero-wait slave
    send_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 8'h05, 1'b1, mk(1'b1, 32'h0, 2'b00, 1'b0, 3));
    drain();
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 8'h05, 1'b1, mk(1'b0, 32'hDEADBEEF, 2'b00, 1'b0, 3));
    drain();

    // Partial strobe, back-to-back commands
    send_cmd(1'b1, 16'h0020, 32'h11223344, 4'hF, 8'h01, 1'b1, mk(1'b1, 32'h0, 2'b00, 1'b0, 3));
    send_cmd(1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, 8'h02, 1'b1, mk(1'b1, 32'h0, 2'b00, 1'b0, 3));
    send_cmd(1'b0, 16'h0020, 32'h0, 4'h0, 8'h03, 1'b1, mk(1'b0, 32'h11BB33DD, 2'b00, 1'b0, 3));
    drain();

    // W held off for 3 cycles while AW is accepted immediately
    s_aw = aw_hs_cnt; s_awv = awv_cycles; s_wv = wv_cycles; s_wdc = wdata_changes;
    w_stall_until = wv_cycles + 3;
    send_cmd(1'b1, 16'h0030, 32'hCAFEF00D, 4'hF, 8'h07, 1'b1, mk(1'b1, 32'h0, 2'b00, 1'b0, 0));
    drain();
    check("order_aw_hs", 64'(aw_hs_cnt - s_aw), 64'd1);
    check("order_awv_cycles", 64'(awv_cycles - s_awv), 64'd1);
    check("order_wv_cycles", 64'(wv_cycles - s_wv), 64'd4);
    check("order_wdata_stable", 64'(wdata_changes - s_wdc), 64'd0);
    send_cmd(1'b0, 16'h0030, 32'h0, 4'h0, 8'h07, 1'b1, mk(1'b0, 32'hCAFEF00D, 2'b00, 1'b0, 3));
    drain();

    // Response backpressure for 5 cycles
    s_bp = bp_cnt;
    rsp_stall_until = rspv_cycles + 5;
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 8'h0A, 1'b1, mk(1'b0, 32'hDEADBEEF, 2'b00, 1'b0, 3));
    send_cmd(1'b0, 16'h0020, 32'h0, 4'h0, 8'h0B, 1'b1, mk(1'b0, 32'h11BB33DD, 2'b00, 1'b0, 3));
    drain();
    check("bp_cycles", 64'(bp_cnt - s_bp), 64'd5);

    // Error paths: wrong BID; SLVERR with RLAST low
    bid_xor = 8'h03;
    send_cmd(1'b1, 16'h0040, 32'h01020304, 4'hF, 8'h05, 1'b1, mk(1'b1, 32'h0, 2'b00, 1'b1, 3));
    drain();
    bid_xor = 8'h00;
    rresp_force = 2'b10;
    rlast_zero  = 1'b1;
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 8'h09, 1'b1, mk(1'b0, 32'hDEADBEEF, 2'b10, 1'b1, 3));
    drain();
    rresp_force = 2'b00;
    rlast_zero  = 1'b0;

    // Reset in the middle of a write request
    aw_stall_until = awv_cycles + 100;
    w_stall_until  = wv_cycles + 100;
    send_cmd(1'b1, 16'h0050, 32'h55555555, 4'hF, 8'h0C, 1'b0, mk(1'b1, 32'h0, 2'b00, 1'b0, 0));
    check("midrst_awvalid_pre", 64'(bus.m_axi_awvalid), 64'd1);
    check("midrst_wvalid_pre", 64'(bus.m_axi_wvalid), 64'd1);
    #3 rst = 1'b0;
    #1;
    check("midrst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
    check("midrst_wvalid", 64'(bus.m_axi_wvalid), 64'd0);
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    aw_stall_until = awv_cycles;
    w_stall_until  = wv_cycles;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("postrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 8'h0D, 1'b1, mk(1'b0, 32'hDEADBEEF, 2'b00, 1'b0, 3));
    drain();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
